// File: rtl/rv32i_hazard_ctrl.sv
// RV32I decode-stage hazard controller: RAW stall or forwarding select, branch flush, perf counters.
// stall_o is combinational; EX-side outputs are registered one cycle after decode.
module rv32i_hazard_ctrl #(
    parameter int DEPTH        = 3,
    parameter int FORWARD_EN   = 0,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [31:0]                instruction_i,
    input  logic                       redirect_i,
    output logic                       stall_o,
    output logic                       bubble_o,
    output logic [31:0]                inst_exec_o,
    output logic [$clog2(DEPTH+1)-1:0] fwd_rs1_sel_o,
    output logic [$clog2(DEPTH+1)-1:0] fwd_rs2_sel_o,
    output logic [CNT_W-1:0]           stall_cnt_o,
    output logic [CNT_W-1:0]           flush_cnt_o
);
    localparam int          SW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       ld;
    } sb_t;

    sb_t             sb_q [1:DEPTH];
    sb_t             sb_d [1:DEPTH];
    logic [31:0]     exec_q, exec_d;
    logic            bubble_q, bubble_d;
    logic [SW-1:0]   fwd1_q, fwd1_d, fwd2_q, fwd2_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [1:0]      flush_q, flush_d;

    logic [4:0]      rs1, rs2, rd;
    logic            use1, use2, wr, is_ld;
    logic            m1, m2;
    logic [SW-1:0]   sel1, sel2;
    logic            hazard, squash, insert;

    assign rs1 = instruction_i[19:15];
    assign rs2 = instruction_i[24:20];
    assign rd  = instruction_i[11:7];

    always_comb begin
        use1  = 1'b0;
        use2  = 1'b0;
        wr    = 1'b0;
        is_ld = 1'b0;
        case (instruction_i[6:0])
            OP_R:                   begin use1 = 1'b1; use2 = 1'b1; wr = 1'b1; end
            OP_B, OP_S:             begin use1 = 1'b1; use2 = 1'b1; end
            OP_IMM, OP_JALR:        begin use1 = 1'b1; wr = 1'b1; end
            OP_LOAD:                begin use1 = 1'b1; wr = 1'b1; is_ld = 1'b1; end
            OP_JAL, OP_LUI, OP_AUIPC: wr = 1'b1;
            default:                ;
        endcase
    end

    // Scan oldest to youngest so the youngest producer overwrites the select.
    always_comb begin
        m1   = 1'b0;
        m2   = 1'b0;
        sel1 = '0;
        sel2 = '0;
        for (int j = DEPTH; j >= 1; j--) begin
            if (sb_q[j].vld && sb_q[j].rd != 5'd0) begin
                if (use1 && sb_q[j].rd == rs1) begin
                    m1   = 1'b1;
                    sel1 = SW'(j);
                end
                if (use2 && sb_q[j].rd == rs2) begin
                    m2   = 1'b1;
                    sel2 = SW'(j);
                end
            end
        end
    end

    always_comb begin
        if (FORWARD_EN != 0)
            hazard = sb_q[1].ld && ((m1 && sel1 == SW'(1)) || (m2 && sel2 == SW'(1)));
        else
            hazard = m1 || m2;
    end

    assign squash  = redirect_i || (flush_q != 2'd0);
    assign stall_o = hazard && !squash;
    assign insert  = stall_o || squash;

    always_comb begin
        sb_d[1] = insert ? '0 : '{vld: wr && (rd != 5'd0), rd: rd, ld: is_ld};
        for (int k = 2; k <= DEPTH; k++)
            sb_d[k] = sb_q[k-1];
        exec_d   = insert ? NOP : instruction_i;
        bubble_d = insert;
        fwd1_d   = (FORWARD_EN != 0 && !insert) ? sel1 : '0;
        fwd2_d   = (FORWARD_EN != 0 && !insert) ? sel2 : '0;
        if (redirect_i)
            flush_d = 2'(FLUSH_CYCLES - 1);
        else if (flush_q != 2'd0)
            flush_d = flush_q - 2'd1;
        else
            flush_d = flush_q;
        stall_cnt_d = (stall_o && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (squash && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 1; k <= DEPTH; k++)
                sb_q[k] <= '0;
            exec_q      <= NOP;
            bubble_q    <= 1'b1;
            fwd1_q      <= '0;
            fwd2_q      <= '0;
            flush_q     <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            for (int k = 1; k <= DEPTH; k++)
                sb_q[k] <= sb_d[k];
            exec_q      <= exec_d;
            bubble_q    <= bubble_d;
            fwd1_q      <= fwd1_d;
            fwd2_q      <= fwd2_d;
            flush_q     <= flush_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign inst_exec_o   = exec_q;
    assign bubble_o      = bubble_q;
    assign fwd_rs1_sel_o = fwd1_q;
    assign fwd_rs2_sel_o = fwd2_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Bench for rv32i_hazard_ctrl: three configurations (stall mode + 2-slot flush, forwarding, deep + 2-bit counters).
module tb_rv32i_hazard_ctrl;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] ADDI_X5   = 32'h0010_0293; // addi x5,x0,1
    localparam logic [31:0] ADD_X6_55 = 32'h0052_8333; // add  x6,x5,x5
    localparam logic [31:0] LW_X5     = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] ADD_X6_50 = 32'h0002_8333; // add  x6,x5,x0
    localparam logic [31:0] ADDI_X7   = 32'h0013_0393; // addi x7,x6,1
    localparam logic [31:0] ADDI_X0   = 32'h0050_0013; // addi x0,x0,5
    localparam logic [31:0] ADD_X6_00 = 32'h0000_0333; // add  x6,x0,x0

    typedef struct {
        logic [31:0] inst;
        logic        bub;
        logic [2:0]  f1;
        logic [2:0]  f2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ins   [3];
    logic        redir [3];
    logic        stall_w [3];
    logic        bub_w   [3];
    logic [31:0] ex_w    [3];
    logic [1:0]  f1_0, f2_0, f1_1, f2_1;
    logic [2:0]  f1_2, f2_2;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [1:0]  sc2, fc2;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    rv32i_hazard_ctrl #(.DEPTH(3), .FORWARD_EN(0), .FLUSH_CYCLES(2), .CNT_W(16)) dut0 (
        .clk_i(clk), .reset_i(rst), .instruction_i(ins[0]), .redirect_i(redir[0]),
        .stall_o(stall_w[0]), .bubble_o(bub_w[0]), .inst_exec_o(ex_w[0]),
        .fwd_rs1_sel_o(f1_0), .fwd_rs2_sel_o(f2_0), .stall_cnt_o(sc0), .flush_cnt_o(fc0));

    rv32i_hazard_ctrl #(.DEPTH(3), .FORWARD_EN(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut1 (
        .clk_i(clk), .reset_i(rst), .instruction_i(ins[1]), .redirect_i(redir[1]),
        .stall_o(stall_w[1]), .bubble_o(bub_w[1]), .inst_exec_o(ex_w[1]),
        .fwd_rs1_sel_o(f1_1), .fwd_rs2_sel_o(f2_1), .stall_cnt_o(sc1), .flush_cnt_o(fc1));

    rv32i_hazard_ctrl #(.DEPTH(6), .FORWARD_EN(0), .FLUSH_CYCLES(1), .CNT_W(2)) dut2 (
        .clk_i(clk), .reset_i(rst), .instruction_i(ins[2]), .redirect_i(redir[2]),
        .stall_o(stall_w[2]), .bubble_o(bub_w[2]), .inst_exec_o(ex_w[2]),
        .fwd_rs1_sel_o(f1_2), .fwd_rs2_sel_o(f2_2), .stall_cnt_o(sc2), .flush_cnt_o(fc2));

    task automatic observe(input int d, output logic st, output logic [31:0] ex, output logic bub,
                           output logic [2:0] a, output logic [2:0] b,
                           output logic [15:0] sc, output logic [15:0] fc);
        st  = stall_w[d];
        ex  = ex_w[d];
        bub = bub_w[d];
        case (d)
            0:       begin a = {1'b0, f1_0}; b = {1'b0, f2_0}; sc = sc0; fc = fc0; end
            1:       begin a = {1'b0, f1_1}; b = {1'b0, f2_1}; sc = sc1; fc = fc1; end
            default: begin a = f1_2; b = f2_2; sc = {14'd0, sc2}; fc = {14'd0, fc2}; end
        endcase
    endtask

    // One decode slot: expectation queued on drive, stall checked mid-cycle, EX side after the edge.
    task automatic cycle(input int d, input logic [31:0] i, input logic r, input logic est,
                         input logic [31:0] eex, input logic ebub, input logic [2:0] ef1,
                         input logic [2:0] ef2, input string nm);
        exp_t e;
        logic st, bub;
        logic [31:0] ex;
        logic [2:0] a, b;
        logic [15:0] sc, fc;
        ins[d]   = i;
        redir[d] = r;
        e.inst = eex; e.bub = ebub; e.f1 = ef1; e.f2 = ef2;
        sbq.push_back(e);
        #3;
        observe(d, st, ex, bub, a, b, sc, fc);
        checks++;
        if (st !== est) begin
            errors++;
            $display("FAIL %s stall_o: got %b want %b", nm, st, est);
        end
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        observe(d, st, ex, bub, a, b, sc, fc);
        checks++;
        if (ex !== e.inst || bub !== e.bub || a !== e.f1 || b !== e.f2) begin
            errors++;
            $display("FAIL %s ex/bub/fwd: got %h %b %0d %0d want %h %b %0d %0d",
                     nm, ex, bub, a, b, e.inst, e.bub, e.f1, e.f2);
        end
        ins[d]   = NOP;
        redir[d] = 1'b0;
    endtask

    task automatic drain(input int d, input int n);
        for (int k = 0; k < n; k++)
            cycle(d, NOP, 1'b0, 1'b0, NOP, 1'b0, 3'd0, 3'd0, "drain");
    endtask

    task automatic test_reset();
        logic st, bub;
        logic [31:0] ex;
        logic [2:0] a, b;
        logic [15:0] sc, fc;
        for (int d = 0; d < 3; d++) begin
            observe(d, st, ex, bub, a, b, sc, fc);
            checks++;
            if (st !== 1'b0 || ex !== NOP || bub !== 1'b1 || a !== 3'd0 || b !== 3'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %b %h %b %0d %0d want 0 00000013 1 0 0",
                         d, st, ex, bub, a, b);
            end
            checks++;
            if (sc !== 16'd0 || fc !== 16'd0) begin
                errors++;
                $display("FAIL reset_counters dut%0d: got %0d %0d want 0 0", d, sc, fc);
            end
        end
    endtask

    task automatic test_raw_stall();
        cycle(0, ADDI_X5, 1'b0, 1'b0, ADDI_X5, 1'b0, 3'd0, 3'd0, "raw_addi");
        for (int k = 0; k < 3; k++)
            cycle(0, ADD_X6_55, 1'b0, 1'b1, NOP, 1'b1, 3'd0, 3'd0, "raw_stall");
        cycle(0, ADD_X6_55, 1'b0, 1'b0, ADD_X6_55, 1'b0, 3'd0, 3'd0, "raw_release");
        checks++;
        if (sc0 !== 16'd3) begin
            errors++;
            $display("FAIL raw_stall_cnt: got %0d want 3", sc0);
        end
        drain(0, 3);
    endtask

    task automatic test_x0();
        for (int d = 0; d < 2; d++) begin
            cycle(d, ADDI_X0, 1'b0, 1'b0, ADDI_X0, 1'b0, 3'd0, 3'd0, "x0_producer");
            cycle(d, ADD_X6_00, 1'b0, 1'b0, ADD_X6_00, 1'b0, 3'd0, 3'd0, "x0_consumer");
        end
    endtask

    task automatic test_forward();
        cycle(1, LW_X5, 1'b0, 1'b0, LW_X5, 1'b0, 3'd0, 3'd0, "fwd_lw");
        cycle(1, ADD_X6_50, 1'b0, 1'b1, NOP, 1'b1, 3'd0, 3'd0, "fwd_load_use");
        cycle(1, ADD_X6_50, 1'b0, 1'b0, ADD_X6_50, 1'b0, 3'd2, 3'd0, "fwd_from_load");
        cycle(1, ADDI_X7, 1'b0, 1'b0, ADDI_X7, 1'b0, 3'd1, 3'd0, "fwd_from_ex");
        checks++;
        if (sc1 !== 16'd1) begin
            errors++;
            $display("FAIL fwd_stall_cnt: got %0d want 1", sc1);
        end
        drain(1, 3);
    endtask

    task automatic test_flush();
        cycle(0, ADDI_X5, 1'b0, 1'b0, ADDI_X5, 1'b0, 3'd0, 3'd0, "flush_setup");
        cycle(0, ADD_X6_55, 1'b1, 1'b0, NOP, 1'b1, 3'd0, 3'd0, "flush_redirect");
        cycle(0, ADD_X6_55, 1'b0, 1'b0, NOP, 1'b1, 3'd0, 3'd0, "flush_slot2");
        checks++;
        if (fc0 !== 16'd2) begin
            errors++;
            $display("FAIL flush_cnt: got %0d want 2", fc0);
        end
        cycle(0, ADD_X6_55, 1'b0, 1'b1, NOP, 1'b1, 3'd0, 3'd0, "flush_then_stall");
        cycle(0, ADD_X6_55, 1'b0, 1'b0, ADD_X6_55, 1'b0, 3'd0, 3'd0, "flush_release");
        checks++;
        if (sc0 !== 16'd4 || fc0 !== 16'd2) begin
            errors++;
            $display("FAIL flush_counts_after: got %0d %0d want 4 2", sc0, fc0);
        end
        drain(0, 3);
    endtask

    task automatic test_saturate();
        cycle(2, ADDI_X5, 1'b0, 1'b0, ADDI_X5, 1'b0, 3'd0, 3'd0, "sat_addi");
        for (int k = 0; k < 6; k++) begin
            cycle(2, ADD_X6_55, 1'b0, 1'b1, NOP, 1'b1, 3'd0, 3'd0, "sat_stall");
            if (k == 2) begin
                checks++;
                if (sc2 !== 2'd3) begin
                    errors++;
                    $display("FAIL sat_cnt_at3: got %0d want 3", sc2);
                end
            end
        end
        checks++;
        if (sc2 !== 2'd3) begin
            errors++;
            $display("FAIL sat_cnt_held: got %0d want 3", sc2);
        end
        cycle(2, ADD_X6_55, 1'b0, 1'b0, ADD_X6_55, 1'b0, 3'd0, 3'd0, "sat_release");
    endtask

    task automatic test_reset_mid_stall();
        cycle(0, ADDI_X5, 1'b0, 1'b0, ADDI_X5, 1'b0, 3'd0, 3'd0, "rst_addi");
        cycle(0, ADD_X6_55, 1'b0, 1'b1, NOP, 1'b1, 3'd0, 3'd0, "rst_stall1");
        ins[0] = ADD_X6_55;
        #2 rst = 1'b1;
        #2;
        checks++;
        if (stall_w[0] !== 1'b0 || ex_w[0] !== NOP || bub_w[0] !== 1'b1 || sc0 !== 16'd0 || fc0 !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_stall: got %b %h %b %0d %0d want 0 00000013 1 0 0",
                     stall_w[0], ex_w[0], bub_w[0], sc0, fc0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(0, ADD_X6_55, 1'b0, 1'b0, ADD_X6_55, 1'b0, 3'd0, 3'd0, "rst_first_decode");
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            ins[d]   = NOP;
            redir[d] = 1'b0;
        end
        #7;
        test_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        test_raw_stall();
        test_x0();
        test_forward();
        test_flush();
        test_saturate();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
